// File: rtl/dot_product_ctrl.sv
// Dot-product sequencing controller.
// Streams `length` element pairs from two synchronous-read memories over a shared
// address, accumulates their unsigned products and returns the sum on a
// valid/ready handshake.
module dot_product_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] mem1_data,
    input  logic [DATA_WIDTH-1:0] mem2_data,
    output logic [LEN_WIDTH-1:0]  elem_count,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    // Number of reads issued so far, counting the one currently on rd_en.
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    // Set when the memories sampled an address on the last edge, so their
    // read data is valid this cycle.
    logic                  s1_valid_q, s1_valid_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [LEN_WIDTH-1:0]  elem_count_q, elem_count_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic [ACC_WIDTH-1:0]  product;

    assign product = ACC_WIDTH'(mem1_data) * ACC_WIDTH'(mem2_data);

    // Next-state logic for the sequencer, read pipeline and accumulator.
    always_comb begin
        state_d        = state_q;
        rd_en_d        = rd_en_q;
        rd_addr_d      = rd_addr_q;
        len_d          = len_q;
        issue_cnt_d    = issue_cnt_q;
        acc_d          = acc_q;
        elem_count_d   = elem_count_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        s1_valid_d     = rd_en_q;

        if (s1_valid_q) begin
            acc_d        = acc_q + product;
            elem_count_d = elem_count_q + LEN_WIDTH'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d        = length;
                    acc_d        = '0;
                    elem_count_d = '0;
                    if (length != '0) begin
                        rd_en_d     = 1'b1;
                        rd_addr_d   = base_addr;
                        issue_cnt_d = LEN_WIDTH'(1);
                        state_d     = StRead;
                    end else begin
                        // Empty vector: answer immediately without touching memory.
                        result_d       = '0;
                        result_valid_d = 1'b1;
                        state_d        = StDone;
                    end
                end
            end
            StRead: begin
                if (issue_cnt_q == len_q) begin
                    rd_en_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
                end
            end
            StDrain: begin
                if (!s1_valid_q && !rd_en_q && (elem_count_q == len_q)) begin
                    result_d       = acc_q;
                    result_valid_d = 1'b1;
                    state_d        = StDone;
                end
            end
            StDone: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            busy_q         <= 1'b0;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= '0;
            len_q          <= '0;
            issue_cnt_q    <= '0;
            s1_valid_q     <= 1'b0;
            acc_q          <= '0;
            elem_count_q   <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            busy_q         <= busy_d;
            rd_en_q        <= rd_en_d;
            rd_addr_q      <= rd_addr_d;
            len_q          <= len_d;
            issue_cnt_q    <= issue_cnt_d;
            s1_valid_q     <= s1_valid_d;
            acc_q          <= acc_d;
            elem_count_q   <= elem_count_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign elem_count   = elem_count_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Testbench for dot_product_ctrl: synchronous-read memory models plus a
// sum-of-products reference computed directly from the memory contents.
module tb_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [5:0]  length = '0;
    logic        busy;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [7:0]  mem1_data = '0;
    logic [7:0]  mem2_data = '0;
    logic [5:0]  elem_count;
    logic [20:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;

    logic [7:0]  mem1 [32];
    logic [7:0]  mem2 [32];

    int n_checks = 0;
    int n_fail   = 0;

    dot_product_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .mem1_data   (mem1_data),
        .mem2_data   (mem2_data),
        .elem_count  (elem_count),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        if (rd_en) begin
            mem1_data <= mem1[rd_addr];
            mem2_data <= mem2[rd_addr];
        end
    end

    function automatic logic [20:0] model(input logic [4:0] base, input logic [5:0] len);
        longint s = 0;
        for (int i = 0; i < int'(len); i++) begin
            int idx = (int'(base) + i) % 32;
            s += longint'(mem1[idx]) * longint'(mem2[idx]);
        end
        return 21'(s);
    endfunction

    // One complete operation, from launch through the result handshake.
    task automatic run_op(input string name, input logic [4:0] base, input logic [5:0] len,
                          input int hold, input bit pulse_start, input bit keep_start,
                          input bit launch, output logic [20:0] got);
        logic [20:0] exp;
        int rd_cnt;
        int valid_k;
        int exp_k;
        exp = model(base, len);
        if (launch) begin
            start     = 1'b1;
            base_addr = base;
            length    = len;
        end
        result_ready = (hold == 0);
        @(negedge clk);
        rd_cnt  = 0;
        valid_k = -1;
        for (int k = 0; k < 200; k++) begin
            if (rd_en) begin
                n_checks++;
                if (rd_addr !== 5'((int'(base) + rd_cnt) % 32)) begin
                    n_fail++;
                    $display("FAIL %s rd_addr[%0d]: got %0d expected %0d", name, rd_cnt,
                             rd_addr, (int'(base) + rd_cnt) % 32);
                end
                n_checks++;
                if (k !== rd_cnt) begin
                    n_fail++;
                    $display("FAIL %s rd_en_gap: read %0d seen at cycle %0d", name, rd_cnt, k);
                end
                rd_cnt++;
            end
            if (result_valid) begin
                valid_k = k;
                break;
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_during_op: got %b expected 1 at cycle %0d", name, busy, k);
            end
            start = keep_start || (pulse_start && k == 1);
            @(negedge clk);
        end
        start = keep_start || pulse_start;
        exp_k = (len == 0) ? 0 : int'(len) + 2;
        n_checks++;
        if (valid_k !== exp_k) begin
            n_fail++;
            $display("FAIL %s valid_latency: got %0d expected %0d (-1 = timeout)", name,
                     valid_k, exp_k);
        end
        n_checks++;
        if (rd_cnt !== int'(len)) begin
            n_fail++;
            $display("FAIL %s read_count: got %0d expected %0d", name, rd_cnt, len);
        end
        n_checks++;
        if (result !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %0h expected %0h", name, result, exp);
        end
        n_checks++;
        if (elem_count !== len) begin
            n_fail++;
            $display("FAIL %s elem_count: got %0d expected %0d", name, elem_count, len);
        end
        got = result;
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b1 || result !== exp || busy !== 1'b1 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold[%0d]: valid=%b result=%0h busy=%b rd_en=%b expected 1/%0h/1/0",
                         name, j, result_valid, result, busy, rd_en, exp);
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            n_fail++;
            $display("FAIL %s handshake: valid=%b busy=%b result=%0h expected 0/0/%0h",
                     name, result_valid, busy, result, exp);
        end
        result_ready = 1'b0;
        start        = keep_start;
        if (!keep_start) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle_after: busy=%b rd_en=%b expected 0/0", name, busy, rd_en);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || rd_addr !== 5'd0 || elem_count !== 6'd0 ||
            result !== 21'd0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b rd_en=%b rd_addr=%0d elem_count=%0d result=%0h valid=%b expected all 0",
                     name, busy, rd_en, rd_addr, elem_count, result, result_valid);
        end
    endtask

    task automatic fill_basic();
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'(8'h11 + i);
            mem2[i] = 8'(8'h21 + i);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [20:0] got;
        fill_basic();
        run_op("basic", 5'd0, 6'd4, 0, 1'b0, 1'b0, 1'b1, got);
        n_checks++;
        if (got !== 21'h9FE) begin
            n_fail++;
            $display("FAIL basic_const: got %0h expected 9fe", got);
        end
    endtask

    task automatic test_wrap();
        logic [20:0] got;
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'(i);
            mem2[i] = 8'd1;
        end
        run_op("wrap", 5'd30, 6'd4, 0, 1'b0, 1'b0, 1'b1, got);
        n_checks++;
        if (got !== 21'd62) begin
            n_fail++;
            $display("FAIL wrap_const: got %0d expected 62", got);
        end
    endtask

    task automatic test_max_length();
        logic [20:0] got;
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'hFF;
            mem2[i] = 8'hFF;
        end
        run_op("max_len", 5'd0, 6'd32, 1, 1'b0, 1'b0, 1'b1, got);
        n_checks++;
        if (got !== 21'h1FC020) begin
            n_fail++;
            $display("FAIL max_len_const: got %0h expected 1fc020", got);
        end
    endtask

    task automatic test_backpressure();
        logic [20:0] got;
        fill_basic();
        run_op("backpressure", 5'd0, 6'd4, 5, 1'b1, 1'b0, 1'b1, got);
    endtask

    task automatic test_length_zero();
        logic [20:0] got;
        fill_basic();
        run_op("len_zero", 5'd7, 6'd0, 3, 1'b0, 1'b0, 1'b1, got);
    endtask

    task automatic test_reset_mid_read();
        logic [20:0] got;
        fill_basic();
        start     = 1'b1;
        base_addr = 5'd0;
        length    = 6'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid_read");
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL after_abort[%0d]: valid=%b busy=%b rd_en=%b expected 0/0/0",
                         i, result_valid, busy, rd_en);
            end
        end
        run_op("post_reset", 5'd0, 6'd4, 0, 1'b0, 1'b0, 1'b1, got);
        n_checks++;
        if (got !== 21'h9FE) begin
            n_fail++;
            $display("FAIL post_reset_const: got %0h expected 9fe", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] got;
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'($urandom_range(0, 255));
            mem2[i] = 8'($urandom_range(0, 255));
        end
        run_op("b2b_first", 5'd5, 6'd3, 0, 1'b0, 1'b1, 1'b1, got);
        run_op("b2b_second", 5'd5, 6'd3, 2, 1'b0, 1'b0, 1'b0, got);
    endtask

    task automatic test_random();
        logic [20:0] got;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] = 8'($urandom_range(0, 255));
                mem2[i] = 8'($urandom_range(0, 255));
            end
            run_op($sformatf("random%0d", n), 5'($urandom_range(0, 31)),
                   6'($urandom_range(1, 32)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), 1'b0, 1'b1, got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_max_length();
        test_backpressure();
        test_length_zero();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_ctrl.md
Name: dot_product_ctrl

Overview:
- Sequencing controller for the dot-product datapath. On `start`, it reads two operand vectors from the two operand memories (mem1, mem2) over a shared address stream.
- Multiplies element pairs and accumulates them into an unsigned sum.
- Presents the sum on a valid/ready result handshake.
- Sits between the top-level command source and the two synchronous-read operand memories, and replaces ad-hoc read sequencing.

Parameters:
- DATA_WIDTH, 8: width of each operand element.
- ADDR_WIDTH, 5: operand memory address width. Memory depth is 2^ADDR_WIDTH.
- LEN_WIDTH, ADDR_WIDTH+1: width of the `length` command field. Maximum length is 2^ADDR_WIDTH.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH: accumulator and result width. It holds a full-length sum of maximum products without overflow.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first element address; captured with start.
- length  in  LEN_WIDTH  number of element pairs; captured with start.
- busy  out  1  high whenever state is not IDLE.
- rd_en  out  1  read enable, shared by mem1 and mem2.
- rd_addr  out  ADDR_WIDTH  read address, shared by both memories.
- mem1_data  in  DATA_WIDTH  mem1 read data; valid the cycle after the memory samples rd_en.
- mem2_data  in  DATA_WIDTH  mem2 read data; same timing as mem1_data.
- elem_count  out  LEN_WIDTH  products accumulated so far in the current operation.
- result  out  ACC_WIDTH  final dot product.
- result_valid  out  1  result handshake valid.
- result_ready  in  1  result handshake ready.

Behaviour:
- Reset values: busy=0, rd_en=0, rd_addr=0, elem_count=0, result=0, result_valid=0, accumulator=0, state=IDLE, pipeline valid flags=0.
- Reset asserted mid-operation aborts the operation immediately. In-flight memory data is discarded and no result is produced.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE, start=1, length>0:
  - capture base_addr and length; clear accumulator and elem_count.
  - go to READ; rd_en=1 and rd_addr=base_addr from the next cycle.
- IDLE, start=1, length=0: go directly to DONE with result=0 and result_valid=1 on the next edge; no reads are issued.
- READ:
  - rd_en is held high for exactly `length` consecutive cycles.
  - rd_addr increments by 1 each cycle, modulo 2^ADDR_WIDTH (base 30 wraps to 31, 0, 1, ...).
  - after the last issue, rd_en=0 and rd_addr holds its last value; go to DRAIN.
- Read pipeline:
  - stage-1 flag = registered rd_en, i.e. the memory sampled an address this edge.
  - stage-2: when the stage-1 flag is set, the next edge adds mem1_data*mem2_data (unsigned, zero-extended to ACC_WIDTH) to the accumulator and increments elem_count.
- DRAIN: wait until the pipeline is empty and elem_count == length. Then load result from the accumulator, set result_valid=1, and go to DONE.
- Latency: with start sampled at edge t and length L, rd_en is high from edge t to edge t+L. The last product is accumulated at edge t+L+1, and result_valid rises at edge t+L+2.
- DONE:
  - result and result_valid are held stable while result_ready=0.
  - at an edge with result_valid && result_ready: result_valid=0 and state goes to IDLE. result keeps its value until the next load.
  - result_ready while result_valid=0 has no effect.
- start while busy=1 is ignored, including the handshake-completion cycle. A new start is accepted only when sampled in IDLE, earliest the cycle after the handshake.
- Back-to-back operation: start held high continuously re-launches each time IDLE is reached.
- Arithmetic: all unsigned; no saturation needed because ACC_WIDTH is sized for the maximum length.

Test Plan:
- Basic: mem1[i]=0x11+i, mem2[i]=0x21+i; base 0, length 4, result_ready=1 -> rd_addr 0,1,2,3 on 4 consecutive rd_en cycles; result=0x9FE (2558); result_valid at start edge+6; elem_count=4.
- Wrap: mem1[i]=i, mem2[i]=1; base 30, length 4 -> rd_addr sequence 30,31,0,1; result=62.
- Max length: all entries 0xFF; base 0, length 32 -> 32 rd_en cycles; result=0x1FC020; no overflow.
- Backpressure and ignored start: basic case with result_ready=0 for 5 cycles and start pulsed during READ and DONE -> exactly one operation; result/result_valid stable until ready; busy drops the edge after the handshake.
- Length 0 -> no rd_en; result=0 with result_valid one edge after start; busy=1 until the handshake.
- Reset mid-READ: assert rst after 2 issued reads -> next edge all outputs at reset values. A subsequent basic run still yields 0x9FE.
